// File: rtl/l1_snoop_responder.sv
// l1_snoop_responder
// Per-core L1-side responder for the coherency snoop channel. Accepts one
// snoop at a time, arbitrates for the L1 arrays, looks up the MESI state,
// streams the full line out when it is dirty (M), writes back the
// downgraded state and returns a single-cycle snoop response.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   snoop_valid_i/ready_o        snoop handshake (ready only in IDLE)
//   snoop_addr_i, snoop_type_i   byte address, 0=RD_SHARED 1=RD_EXCL 2=INV 3=rsvd
//   snoop_rsp_valid_o            one-cycle response pulse
//   snoop_rsp_data_en_o          response carries line data
//   snoop_rsp_data_o             line, word 0 in LSBs (zero when no data)
//   arr_req_o / arr_gnt_i        L1 array ownership request / grant level
//   lk_en_o, lk_addr_o           tag/state lookup strobe and line address
//   lk_hit_i, lk_state_i         lookup result, one cycle after lk_en_o
//   dr_en_o, dr_addr_o           data word read strobe and word address
//   dr_data_i                    read data, one cycle after dr_en_o
//   st_wr_en_o, st_addr_o,
//   st_state_o                   MESI state write-back
//   stat_hits_o, stat_misses_o,
//   stat_wbacks_o                saturating statistics (SNOOP_STATS_EN only)
//   snoop_busy_o                 high from accept through the response cycle
//
// Build option: define SNOOP_STATS_EN to add the statistics counters.

module l1_snoop_responder #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_BYTES = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              snoop_valid_i,
    output logic                              snoop_ready_o,
    input  logic [ADDR_W-1:0]                 snoop_addr_i,
    input  logic [1:0]                        snoop_type_i,
    output logic                              snoop_rsp_valid_o,
    output logic                              snoop_rsp_data_en_o,
    output logic [(LINE_BYTES/4)*DATA_W-1:0]  snoop_rsp_data_o,
    output logic                              arr_req_o,
    input  logic                              arr_gnt_i,
    output logic                              lk_en_o,
    output logic [ADDR_W-1:0]                 lk_addr_o,
    input  logic                              lk_hit_i,
    input  logic [1:0]                        lk_state_i,
    output logic                              dr_en_o,
    output logic [ADDR_W-1:0]                 dr_addr_o,
    input  logic [DATA_W-1:0]                 dr_data_i,
    output logic                              st_wr_en_o,
    output logic [ADDR_W-1:0]                 st_addr_o,
    output logic [1:0]                        st_state_o,
`ifdef SNOOP_STATS_EN
    output logic [31:0]                       stat_hits_o,
    output logic [31:0]                       stat_misses_o,
    output logic [31:0]                       stat_wbacks_o,
`endif
    output logic                              snoop_busy_o
);

    localparam int unsigned WORDS  = LINE_BYTES / 4;
    localparam int unsigned LINE_W = WORDS * DATA_W;
    localparam int unsigned IDX_W  = $clog2(WORDS);
    localparam int unsigned CNT_W  = IDX_W + 1;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_M = 2'd3;
    localparam logic [1:0] TY_RD_SHARED = 2'd0;
    localparam logic [1:0] TY_RSVD      = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_LOOKUP, S_LK_WAIT, S_READ_DATA, S_UPDATE, S_RESPOND
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          type_q;
    logic                data_en_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   line_q [WORDS];
    logic [LINE_W-1:0]   line_flat;

    logic accept;
    logic lk_skip;      // reserved type, miss or invalid line: respond without data/update
    logic lk_dirty;
    logic last_word;

    assign accept    = (state_q == S_IDLE) && snoop_valid_i;
    assign lk_skip   = (type_q == TY_RSVD) || !lk_hit_i || (lk_state_i == MESI_I);
    assign lk_dirty  = lk_state_i == MESI_M;
    assign last_word = cnt_q == CNT_W'(WORDS);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (snoop_valid_i) state_d = S_ARB;
            S_ARB:       if (arr_gnt_i) state_d = S_LOOKUP;
            S_LOOKUP:    state_d = S_LK_WAIT;
            S_LK_WAIT: begin
                if (lk_skip)       state_d = S_RESPOND;
                else if (lk_dirty) state_d = S_READ_DATA;
                else               state_d = S_UPDATE;
            end
            S_READ_DATA: if (last_word) state_d = S_UPDATE;
            S_UPDATE:    state_d = S_RESPOND;
            S_RESPOND:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        snoop_ready_o       = 1'b0;
        snoop_busy_o        = 1'b0;
        arr_req_o           = 1'b0;
        lk_en_o             = 1'b0;
        lk_addr_o           = '0;
        dr_en_o             = 1'b0;
        dr_addr_o           = '0;
        st_wr_en_o          = 1'b0;
        st_addr_o           = '0;
        st_state_o          = MESI_I;
        snoop_rsp_valid_o   = 1'b0;
        snoop_rsp_data_en_o = 1'b0;
        snoop_rsp_data_o    = '0;
        if (state_q == S_IDLE) begin
            snoop_ready_o = 1'b1;
        end else begin
            snoop_busy_o = 1'b1;
            arr_req_o    = 1'b1;
        end
        unique case (state_q)
            S_LOOKUP: begin
                lk_en_o   = 1'b1;
                lk_addr_o = addr_q;
            end
            S_READ_DATA: if (!last_word) begin
                dr_en_o   = 1'b1;
                dr_addr_o = addr_q + ADDR_W'({cnt_q, 2'b00});
            end
            S_UPDATE: begin
                st_wr_en_o = 1'b1;
                st_addr_o  = addr_q;
                st_state_o = (type_q == TY_RD_SHARED) ? MESI_S : MESI_I;
            end
            S_RESPOND: begin
                snoop_rsp_valid_o   = 1'b1;
                snoop_rsp_data_en_o = data_en_q;
                snoop_rsp_data_o    = data_en_q ? line_flat : '0;
            end
            default: ;
        endcase
    end

    // Request capture, word counter and line buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            type_q    <= '0;
            data_en_q <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < int'(WORDS); i++) line_q[i] <= '0;
        end else begin
            if (accept) begin
                addr_q    <= snoop_addr_i & ~ADDR_W'(LINE_BYTES - 1);
                type_q    <= snoop_type_i;
                data_en_q <= 1'b0;
                cnt_q     <= '0;
            end
            if (state_q == S_LK_WAIT) begin
                data_en_q <= !lk_skip && lk_dirty;
                cnt_q     <= '0;
            end
            if (state_q == S_READ_DATA) begin
                cnt_q <= cnt_q + CNT_W'(1);
                // Data for word k arrives while the counter shows k+1
                if (cnt_q != '0) line_q[IDX_W'(cnt_q - CNT_W'(1))] <= dr_data_i;
            end
        end
    end

    // Flatten the line buffer, word 0 in the LSBs
    always_comb begin
        line_flat = '0;
        for (int i = 0; i < int'(WORDS); i++) line_flat[i*DATA_W +: DATA_W] = line_q[i];
    end

`ifdef SNOOP_STATS_EN
    logic        hit_q;
    logic [31:0] hits_q, misses_q, wbacks_q;

    // Saturating counters, bumped in the response cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q    <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
            wbacks_q <= '0;
        end else begin
            if (accept) hit_q <= 1'b0;
            if (state_q == S_LK_WAIT) hit_q <= lk_hit_i && (lk_state_i != MESI_I);
            if (state_q == S_RESPOND) begin
                if (hit_q && (hits_q != '1))      hits_q   <= hits_q + 32'd1;
                if (!hit_q && (misses_q != '1))   misses_q <= misses_q + 32'd1;
                if (data_en_q && (wbacks_q != '1)) wbacks_q <= wbacks_q + 32'd1;
            end
        end
    end

    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
    assign stat_wbacks_o = wbacks_q;
`endif

    // Grant must stay asserted once the arrays are owned
    a_gnt_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q inside {S_LOOKUP, S_LK_WAIT, S_READ_DATA, S_UPDATE}) |-> arr_gnt_i);

endmodule

// File: tb/tb_l1_snoop_responder.sv
// Directed bench for l1_snoop_responder: small lookup/data-array responders,
// a negedge monitor that records strobes and responses, and a linear
// sequence of directed snoops with hand-computed expectations.
module tb_l1_snoop_responder;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LINE_W = 512;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                snoop_valid_i;
    logic                snoop_ready_o;
    logic [ADDR_W-1:0]   snoop_addr_i;
    logic [1:0]          snoop_type_i;
    logic                snoop_rsp_valid_o;
    logic                snoop_rsp_data_en_o;
    logic [LINE_W-1:0]   snoop_rsp_data_o;
    logic                arr_req_o;
    logic                arr_gnt_i;
    logic                lk_en_o;
    logic [ADDR_W-1:0]   lk_addr_o;
    logic                lk_hit_i;
    logic [1:0]          lk_state_i;
    logic                dr_en_o;
    logic [ADDR_W-1:0]   dr_addr_o;
    logic [DATA_W-1:0]   dr_data_i;
    logic                st_wr_en_o;
    logic [ADDR_W-1:0]   st_addr_o;
    logic [1:0]          st_state_o;
    logic                snoop_busy_o;

    l1_snoop_responder dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .snoop_valid_i       (snoop_valid_i),
        .snoop_ready_o       (snoop_ready_o),
        .snoop_addr_i        (snoop_addr_i),
        .snoop_type_i        (snoop_type_i),
        .snoop_rsp_valid_o   (snoop_rsp_valid_o),
        .snoop_rsp_data_en_o (snoop_rsp_data_en_o),
        .snoop_rsp_data_o    (snoop_rsp_data_o),
        .arr_req_o           (arr_req_o),
        .arr_gnt_i           (arr_gnt_i),
        .lk_en_o             (lk_en_o),
        .lk_addr_o           (lk_addr_o),
        .lk_hit_i            (lk_hit_i),
        .lk_state_i          (lk_state_i),
        .dr_en_o             (dr_en_o),
        .dr_addr_o           (dr_addr_o),
        .dr_data_i           (dr_data_i),
        .st_wr_en_o          (st_wr_en_o),
        .st_addr_o           (st_addr_o),
        .st_state_o          (st_state_o),
        .snoop_busy_o        (snoop_busy_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc_n = 0;

    // Lookup and data-array responders
    logic              mdl_hit   = 1'b0;
    logic [1:0]        mdl_state = 2'd0;
    logic [ADDR_W-1:0] mdl_base  = '0;

    always @(posedge clk) begin
        cyc_n      <= cyc_n + 1;
        lk_hit_i   <= lk_en_o & mdl_hit;
        lk_state_i <= lk_en_o ? mdl_state : 2'd0;
        dr_data_i  <= dr_en_o ? (32'hA000_0000 + ((dr_addr_o - mdl_base) >> 2)) : 32'd0;
    end

    // Monitor, sampled on the falling edge
    int                acc_cnt, acc_cyc, lk_cnt, dr_cnt, dr_bad, st_cnt, rsp_cnt, rsp_cyc;
    logic [ADDR_W-1:0] lk_addr_s, st_addr_s;
    logic [1:0]        st_state_s;
    logic              rsp_den_s;
    logic [LINE_W-1:0] rsp_data_s;

    always @(negedge clk) begin
        if (snoop_valid_i && snoop_ready_o) begin
            acc_cnt++;
            acc_cyc = cyc_n;
        end
        if (lk_en_o) begin
            lk_cnt++;
            lk_addr_s = lk_addr_o;
        end
        if (dr_en_o) begin
            if (dr_addr_o !== mdl_base + ADDR_W'(4 * dr_cnt)) dr_bad++;
            dr_cnt++;
        end
        if (st_wr_en_o) begin
            st_cnt++;
            st_addr_s  = st_addr_o;
            st_state_s = st_state_o;
        end
        if (snoop_rsp_valid_o) begin
            rsp_cnt++;
            rsp_cyc    = cyc_n;
            rsp_den_s  = snoop_rsp_data_en_o;
            rsp_data_s = snoop_rsp_data_o;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        acc_cnt = 0; lk_cnt = 0; dr_cnt = 0; dr_bad = 0; st_cnt = 0; rsp_cnt = 0;
        acc_cyc = 0; rsp_cyc = 0;
        lk_addr_s = '0; st_addr_s = '0; st_state_s = '0; rsp_den_s = 1'b0; rsp_data_s = '0;
    endtask

    // Present one snoop for a single cycle (DUT is idle)
    task automatic do_snoop(input logic [ADDR_W-1:0] a, input logic [1:0] t);
        snoop_addr_i  = a;
        snoop_type_i  = t;
        snoop_valid_i = 1'b1;
        @(posedge clk); #1;
        snoop_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (rsp_cnt == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({tag, "_rsp_seen"}, 64'(rsp_cnt != 0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        snoop_valid_i = 1'b0;
        snoop_addr_i  = '0;
        snoop_type_i  = '0;
        arr_gnt_i     = 1'b1;
        clr();

        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready",   64'(snoop_ready_o),     64'd1);
        chk("rst_rsp",     64'(snoop_rsp_valid_o), 64'd0);
        chk("rst_arr_req", 64'(arr_req_o),         64'd0);
        chk("rst_lk_en",   64'(lk_en_o),           64'd0);
        chk("rst_dr_en",   64'(dr_en_o),           64'd0);
        chk("rst_st_wr",   64'(st_wr_en_o),        64'd0);
        chk("rst_busy",    64'(snoop_busy_o),      64'd0);

        // READ_SHARED clean hit (E -> S), 5-cycle latency
        clr();
        mdl_hit = 1'b1; mdl_state = 2'd2; mdl_base = 32'h0000_1040;
        do_snoop(32'h0000_1044, 2'd0);
        wait_rsp("rs_e");
        chk("rs_e_lk_addr",  64'(lk_addr_s),         64'h1040);
        chk("rs_e_st_cnt",   64'(st_cnt),            64'd1);
        chk("rs_e_st_state", 64'(st_state_s),        64'd1);
        chk("rs_e_st_addr",  64'(st_addr_s),         64'h1040);
        chk("rs_e_den",      64'(rsp_den_s),         64'd0);
        chk("rs_e_data",     64'(rsp_data_s == '0),  64'd1);
        chk("rs_e_lat",      64'(rsp_cyc - acc_cyc), 64'd5);
        chk("rs_e_dr_cnt",   64'(dr_cnt),            64'd0);
        chk("rs_e_ready",    64'(snoop_ready_o),     64'd1);
        chk("rs_e_arr_req",  64'(arr_req_o),         64'd0);

        // READ_EXCL on a dirty line: 16 word reads, state -> I, data returned
        clr();
        mdl_hit = 1'b1; mdl_state = 2'd3; mdl_base = 32'h0000_1040;
        do_snoop(32'h0000_1048, 2'd1);
        wait_rsp("rx_m");
        chk("rx_m_dr_cnt",   64'(dr_cnt),            64'd16);
        chk("rx_m_dr_addr",  64'(dr_bad),            64'd0);
        chk("rx_m_st_cnt",   64'(st_cnt),            64'd1);
        chk("rx_m_st_state", 64'(st_state_s),        64'd0);
        chk("rx_m_den",      64'(rsp_den_s),         64'd1);
        chk("rx_m_lat",      64'(rsp_cyc - acc_cyc), 64'd22);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("rx_m_word%0d", k), 64'(rsp_data_s[k*32 +: 32]), 64'hA000_0000 + 64'(k));
        end

        // INVALIDATE miss: no update, no reads, 4-cycle latency
        clr();
        mdl_hit = 1'b0; mdl_state = 2'd0; mdl_base = 32'h0000_1040;
        do_snoop(32'h0000_107F, 2'd2);
        wait_rsp("inv_miss");
        chk("inv_miss_st_cnt", 64'(st_cnt),            64'd0);
        chk("inv_miss_dr_cnt", 64'(dr_cnt),            64'd0);
        chk("inv_miss_den",    64'(rsp_den_s),         64'd0);
        chk("inv_miss_lat",    64'(rsp_cyc - acc_cyc), 64'd4);
        chk("inv_miss_lk",     64'(lk_addr_s),         64'h1040);

        // Reserved type hitting an M line behaves like a miss
        clr();
        mdl_hit = 1'b1; mdl_state = 2'd3; mdl_base = 32'h0000_1040;
        do_snoop(32'h0000_1040, 2'd3);
        wait_rsp("rsvd");
        chk("rsvd_st_cnt", 64'(st_cnt),            64'd0);
        chk("rsvd_dr_cnt", 64'(dr_cnt),            64'd0);
        chk("rsvd_den",    64'(rsp_den_s),         64'd0);
        chk("rsvd_lat",    64'(rsp_cyc - acc_cyc), 64'd4);

        // Grant withheld 10 cycles with valid held: one accept only
        clr();
        arr_gnt_i = 1'b0;
        mdl_hit = 1'b1; mdl_state = 2'd1; mdl_base = 32'h0000_2000;
        snoop_addr_i = 32'h0000_2010; snoop_type_i = 2'd0; snoop_valid_i = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        chk("gnt_wait_lk",    64'(lk_cnt),        64'd0);
        chk("gnt_wait_acc",   64'(acc_cnt),       64'd1);
        chk("gnt_wait_ready", 64'(snoop_ready_o), 64'd0);
        chk("gnt_wait_req",   64'(arr_req_o),     64'd1);
        chk("gnt_wait_busy",  64'(snoop_busy_o),  64'd1);
        arr_gnt_i = 1'b1;
        wait_rsp("gnt_a");
        chk("gnt_a_acc",   64'(acc_cnt),       64'd1);
        chk("gnt_a_ready", 64'(snoop_ready_o), 64'd1);
        @(posedge clk); #1;
        snoop_valid_i = 1'b0;
        chk("gnt_b_acc",   64'(acc_cnt),       64'd2);
        rsp_cnt = 0;
        wait_rsp("gnt_b");
        chk("gnt_b_lk",    64'(lk_cnt),        64'd2);
        chk("gnt_b_st",    64'(st_state_s),    64'd1);
        chk("gnt_b_lat",   64'(rsp_cyc - acc_cyc), 64'd5);

        // Reset during word 7 of the line read aborts the snoop
        clr();
        mdl_hit = 1'b1; mdl_state = 2'd3; mdl_base = 32'h0000_3000;
        do_snoop(32'h0000_3000, 2'd1);
        begin
            int n = 0;
            while (!(dr_en_o && dr_addr_o == 32'h0000_301C) && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("abort_reach_idx7", 64'(dr_en_o && dr_addr_o == 32'h0000_301C), 64'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_dr_en",   64'(dr_en_o),           64'd0);
        chk("abort_arr_req", 64'(arr_req_o),         64'd0);
        chk("abort_st_wr",   64'(st_wr_en_o),        64'd0);
        chk("abort_rsp",     64'(snoop_rsp_valid_o), 64'd0);
        chk("abort_busy",    64'(snoop_busy_o),      64'd0);
        clr();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_rsp",  64'(rsp_cnt),           64'd0);
        chk("abort_no_dr",   64'(dr_cnt),            64'd0);
        chk("abort_ready",   64'(snoop_ready_o),     64'd1);

        // Normal operation after the abort: READ_SHARED hit on S
        clr();
        mdl_hit = 1'b1; mdl_state = 2'd1; mdl_base = 32'h0000_4000;
        do_snoop(32'h0000_4004, 2'd0);
        wait_rsp("post");
        chk("post_lk_addr", 64'(lk_addr_s),         64'h4000);
        chk("post_st",      64'(st_state_s),        64'd1);
        chk("post_lat",     64'(rsp_cyc - acc_cyc), 64'd5);
        chk("post_den",     64'(rsp_den_s),         64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
